// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the instruction address, applies
// PC-relative branches and calls, returns through a small LIFO stack and
// runs the start/halt/done handshake with the harness.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset; PC parked at 0
// RUN    | executing, one instruction per cycle unless stalled
// HALTED | halt instruction seen; PC held, done high until restart
module pc_sequencer #(
    parameter int D           = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_en,
    input  logic         taken,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [D-1:0] target,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         stack_err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    // One extra bit so that "full" (sp == STACK_DEPTH) is representable.
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [D-1:0]    pc_nxt;
    logic            running_nxt, done_nxt, err_nxt;
    logic [SP_W-1:0] sp, sp_nxt, sp_dec;
    logic            push;
    logic [D-1:0]    pc_inc, pc_tgt;
    logic            stack_empty, stack_full;
    logic [D-1:0]    stack_mem [STACK_DEPTH];

    assign pc_inc      = prog_ctr + D'(1);
    // target is two's complement; a plain D-bit add gives the signed,
    // silently wrapping PC-relative result.
    assign pc_tgt      = prog_ctr + target;
    assign sp_dec      = sp - SP_W'(1);
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));

    // State, PC, flags and stack pointer registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            stack_err <= 1'b0;
            sp        <= '0;
        end else begin
            state     <= state_nxt;
            prog_ctr  <= pc_nxt;
            running   <= running_nxt;
            done      <= done_nxt;
            stack_err <= err_nxt;
            sp        <= sp_nxt;
        end
    end

    // Return-address storage; contents are meaningless below the pointer
    // so no reset is needed.
    always_ff @(posedge Clk) begin
        if (push) begin
            stack_mem[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

    // Next-state, next-PC and stack control. Within RUN the if/else chain
    // encodes halt > ret > call > taken branch > sequential step, which also
    // guarantees push and pop never happen together.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = prog_ctr;
        running_nxt = running;
        done_nxt    = done;
        err_nxt     = stack_err;
        sp_nxt      = sp;
        push        = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    pc_nxt      = '0;
                    running_nxt = 1'b1;
                    done_nxt    = 1'b0;
                    sp_nxt      = '0;
                end
            end

            RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_nxt   = HALTED;
                        running_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else if (ret_en) begin
                        if (!stack_empty) begin
                            pc_nxt = stack_mem[sp_dec[IDX_W-1:0]];
                            sp_nxt = sp_dec;
                        end else begin
                            pc_nxt  = pc_inc;
                            err_nxt = 1'b1;
                        end
                    end else if (call_en) begin
                        pc_nxt = pc_tgt;
                        if (!stack_full) begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (branch_en && taken) begin
                        pc_nxt = pc_tgt;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end

            HALTED: begin
                if (start) begin
                    state_nxt   = RUN;
                    pc_nxt      = '0;
                    running_nxt = 1'b1;
                    done_nxt    = 1'b0;
                    sp_nxt      = '0;
                end
            end

            default: begin
                state_nxt   = IDLE;
                pc_nxt      = '0;
                running_nxt = 1'b0;
                done_nxt    = 1'b0;
                sp_nxt      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives one cycle of control
// inputs and compares the registered outputs against hand-computed values.
module tb_pc_sequencer;

    localparam int D = 12;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start, stall, halt, branch_en, taken, call_en, ret_en;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         running, done, stack_err;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(.D(D), .STACK_DEPTH(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .branch_en (branch_en),
        .taken     (taken),
        .call_en   (call_en),
        .ret_en    (ret_en),
        .target    (target),
        .prog_ctr  (prog_ctr),
        .running   (running),
        .done      (done),
        .stack_err (stack_err)
    );

    // 10 ns clock.
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt = 0; branch_en = 0; taken = 0;
        call_en = 0; ret_en = 0; target = '0;
    endtask

    // Advance one edge, sample 1 ns later, then return inputs to idle.
    task automatic tick();
        @(posedge Clk);
        #1;
        clear_inputs();
    endtask

    task automatic step_pc(input string tag, input logic [D-1:0] exp_pc);
        tick();
        check(tag, 32'(prog_ctr), 32'(exp_pc));
    endtask

    task automatic check_flags(input string tag, input logic r, input logic d, input logic e);
        check({tag, ".running"}, 32'(running), 32'(r));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".stack_err"}, 32'(stack_err), 32'(e));
    endtask

    task automatic halt_restart();
        halt = 1;
        tick();
        start = 1;
        tick();
    endtask

    initial begin
        clear_inputs();
        Reset = 1;
        tick();
        Reset = 1;
        tick();
        check("reset.pc", 32'(prog_ctr), 32'h0);
        check_flags("reset", 0, 0, 0);
        Reset = 0;

        // Ignored inputs in IDLE
        halt = 1; branch_en = 1; taken = 1; target = 12'h010;
        step_pc("idle.hold", 12'h000);
        check("idle.running", 32'(running), 32'h0);

        // Start and sequential stepping
        start = 1;
        step_pc("start.pc", 12'h000);
        check_flags("start", 1, 0, 0);
        for (int i = 1; i <= 5; i++) step_pc($sformatf("seq%0d", i), D'(i));

        // Halt at 5
        halt = 1;
        step_pc("halt.pc", 12'h005);
        check_flags("halt", 0, 1, 0);
        step_pc("halted.hold", 12'h005);

        // Restart from HALTED
        start = 1;
        step_pc("restart.pc", 12'h000);
        check_flags("restart", 1, 0, 0);
        for (int i = 1; i <= 10; i++) tick();
        check("reach10", 32'(prog_ctr), 32'd10);

        // Branches
        branch_en = 1; taken = 1; target = 12'hFFB;
        step_pc("br.back", 12'd5);
        branch_en = 1; taken = 0; target = 12'hFFB;
        step_pc("br.not_taken", 12'd6);
        branch_en = 1; taken = 1; target = 12'h014;
        step_pc("br.fwd", 12'd26);

        // Call / return, nested to overflow, then underflow
        halt_restart();
        check("call.base", 32'(prog_ctr), 32'h0);
        tick(); tick(); tick();
        call_en = 1; target = 12'h014;
        step_pc("call.at3", 12'd23);
        ret_en = 1;
        step_pc("ret.to4", 12'd4);
        call_en = 1; target = 12'h001; step_pc("nest1", 12'd5);
        call_en = 1; target = 12'h001; step_pc("nest2", 12'd6);
        call_en = 1; target = 12'h001; step_pc("nest3", 12'd7);
        call_en = 1; target = 12'h001; step_pc("nest4", 12'd8);
        check("nest4.err", 32'(stack_err), 32'h0);
        call_en = 1; target = 12'h002; step_pc("nest5.overflow", 12'd10);
        check("overflow.err", 32'(stack_err), 32'h1);
        ret_en = 1; step_pc("unwind1", 12'd8);
        ret_en = 1; step_pc("unwind2", 12'd7);
        ret_en = 1; step_pc("unwind3", 12'd6);
        ret_en = 1; step_pc("unwind4", 12'd5);
        ret_en = 1; step_pc("underflow.pc", 12'd6);
        check("underflow.err", 32'(stack_err), 32'h1);

        // Restart from HALTED empties stack; stack_err remains sticky
        call_en = 1; target = 12'h004; step_pc("pre_halt.call", 12'd10);
        halt_restart();
        check("restart2.err", 32'(stack_err), 32'h1);
        ret_en = 1; step_pc("restart.stack_empty", 12'd1);

        // Wrap-around
        halt_restart();
        branch_en = 1; taken = 1; target = 12'hFFF;
        step_pc("wrap.neg", 12'hFFF);
        step_pc("wrap.inc", 12'h000);

        // Stall freezes everything, including halt
        for (int i = 0; i < 3; i++) begin
            stall = 1; halt = 1; branch_en = 1; taken = 1; target = 12'h005;
            step_pc($sformatf("stall%0d.pc", i), 12'h000);
            check($sformatf("stall%0d.running", i), 32'(running), 32'h1);
        end
        halt = 1; branch_en = 1; taken = 1; target = 12'h005;
        step_pc("stall.release", 12'h000);
        check("stall.release.done", 32'(done), 32'h1);

        // Reset mid-RUN at PC=40 with two entries on the stack
        start = 1; tick();
        call_en = 1; target = 12'h014; step_pc("deep.call1", 12'd20);
        call_en = 1; target = 12'h014; step_pc("deep.call2", 12'd40);
        Reset = 1; call_en = 1; target = 12'h014;
        step_pc("midrun.reset.pc", 12'h000);
        check_flags("midrun.reset", 0, 0, 0);
        Reset = 0;
        step_pc("post_reset.idle", 12'h000);
        check("post_reset.running", 32'(running), 32'h0);
        start = 1;
        step_pc("post_reset.start", 12'h000);
        ret_en = 1;
        step_pc("post_reset.empty_ret", 12'd1);
        check("post_reset.err", 32'(stack_err), 32'h1);
        step_pc("post_reset.step", 12'd2);

        // Back-to-back call/ret, start ignored in RUN, self-loop
        call_en = 1; target = 12'h00A; step_pc("b2b.call", 12'd12);
        ret_en = 1; step_pc("b2b.ret", 12'd3);
        start = 1; step_pc("run.start_ignored", 12'd4);
        branch_en = 1; taken = 1; target = 12'h000;
        step_pc("selfloop", 12'd4);
        check_flags("final", 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Bound total run time so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer consuming the signed 12-bit branch offset produced by the branch-target controller. Holds the instruction address, steps it each cycle, applies PC-relative branches/calls from the offset, returns via a small return-address stack, and runs a start/halt/done handshake with the test harness. It drives the instruction-memory address and is the sole owner of the PC register.

## Interface
- D, 12, PC and offset width in bits
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)

- Clk  input  1  clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high; the clock is the only clock
- start  input  1  begin program execution at address 0
- stall  input  1  freeze PC and stack this cycle (RUN only)
- halt  input  1  current instruction is the halt/done instruction
- branch_en  input  1  current instruction is a conditional branch
- taken  input  1  branch condition true (qualifies branch_en only)
- call_en  input  1  current instruction is call (unconditional)
- ret_en  input  1  current instruction is return
- target  input  D  signed two's-complement PC-relative offset
- prog_ctr  output  D  current instruction address (registered)
- running  output  1  high in RUN
- done  output  1  high in HALTED
- stack_err  output  1  sticky overflow/underflow flag

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- Reset values: prog_ctr=0, running=0, done=0, stack_err=0, stack pointer=0 (empty); stack contents don't-care.
- IDLE: start=1 → RUN, prog_ctr=0. All other inputs ignored.
- RUN, stall=1: PC, stack, state unchanged (halt also ignored while stalled).
- RUN, stall=0, priority (highest first):
  - halt → HALTED; prog_ctr holds.
  - ret_en: stack non-empty → prog_ctr = popped value; empty → prog_ctr = PC+1, stack_err set.
  - call_en: push PC+1, prog_ctr = PC+target; stack full → push dropped, stack_err set, jump still taken.
  - branch_en & taken → prog_ctr = PC+target.
  - otherwise (incl. branch_en & !taken) → prog_ctr = PC+1.
- HALTED: start=1 → RUN, prog_ctr=0, done cleared, stack emptied; stack_err keeps value. Otherwise hold.
- start while RUN: ignored.
- Arithmetic: D-bit modular add, target sign-interpreted; wraps silently (0 + (−1) = 0xFFF; 0xFFF + 1 = 0). target=0 is a legal self-loop.
- Stack is LIFO; push and pop never occur in the same cycle (priority guarantees it).
- stack_err clears only on Reset.

## Timing
- Control inputs are combinational decodes of the instruction at prog_ctr, sampled at the edge; the new prog_ctr is visible after that edge (one-cycle latency, one instruction per cycle).
- running/done are registered and change on the same edge as the state transition: done rises on the edge that samples halt.
- Call followed immediately by ret (next cycle) returns to call address+1 with no bubble.
- Reset has priority over everything, including mid-RUN and mid-stall: next edge gives IDLE, prog_ctr=0, stack empty, stack_err=0.
- Inputs are don't-care in IDLE and HALTED except start and Reset.

## Test plan
- Reset, start pulse, 5 idle cycles → prog_ctr 0,1,2,3,4,5; running=1; halt at PC=5 → done=1 next edge, prog_ctr stays 5.
- At PC=10: branch_en=1, taken=1, target=0xFFB (−5) → 5; at PC=5 taken=0 → 6; target=0x014 (+20) from 6 → 26.
- Call at PC=3 with target=+20 → 23; ret at 23 → 4; nested calls depth 4 then returns unwind in order 3+1..; fifth nested call → stack_err=1, jump taken, later returns yield only 4 entries then underflow → PC+1.
- Wrap: PC=0, branch target=0xFFF → 0xFFF; next step → 0x000.
- stall=1 for 3 cycles with halt=1 and branch_en asserted → prog_ctr, state frozen; stall released → halt honoured.
- Reset asserted mid-RUN at PC=40 with stack depth 2 and stack_err=1 → next edge prog_ctr=0, IDLE, done=0, stack_err=0; start again runs from 0; start from HALTED restarts at 0 with done cleared.
